disp_scan_ctrl: RTL and testbench



---
 rtl/disp_scan_if.sv | 24 ++
 rtl/disp_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_disp_scan_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/disp_scan_if.sv
// Update bus and per-slot display outputs of the 4-digit scan controller.
// The controller uses the slave modport; the driving environment uses master.
interface disp_scan_if;
  logic        upd;
  logic [15:0] hexs;
  logic [3:0]  points;
  logic [3:0]  le_mask;
  logic [3:0]  blink;
  logic [3:0]  an;
  logic [3:0]  dig;
  logic        point_out;
  logic        le_out;
  logic        frame_done;

  modport master (
    output upd, hexs, points, le_mask, blink,
    input  an, dig, point_out, le_out, frame_done
  );

  modport slave (
    input  upd, hexs, points, le_mask, blink,
    output an, dig, point_out, le_out, frame_done
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scan controller.
// New content is staged on upd and moved into the displayed shadow set only at the 3->0 wrap.
module disp_scan_ctrl #(
  parameter int SCAN_DIV  = 17,
  parameter int BLINK_DIV = 25
) (
  input logic        clk,
  input logic        rst_n,
  disp_scan_if.slave bus
);

  localparam logic [SCAN_DIV-1:0]  SCAN_ONE  = {{(SCAN_DIV-1){1'b0}}, 1'b1};
  localparam logic [BLINK_DIV-1:0] BLINK_ONE = {{(BLINK_DIV-1){1'b0}}, 1'b1};

  logic [SCAN_DIV-1:0]  scan_cnt_r;
  logic [BLINK_DIV-1:0] blink_cnt_r;
  logic [1:0]           idx_r;

  logic [15:0] st_hexs_r,  sh_hexs_r,  st_hexs_s,  sh_hexs_s;
  logic [3:0]  st_pts_r,   sh_pts_r,   st_pts_s,   sh_pts_s;
  logic [3:0]  st_le_r,    sh_le_r,    st_le_s,    sh_le_s;
  logic [3:0]  st_blink_r, sh_blink_r, st_blink_s, sh_blink_s;
  logic        pending_r,  pending_s;

  logic [3:0] an_r, dig_r;
  logic       point_r, le_r, frame_done_r;

  logic tick_s, wrap_s, bphase_s;

  assign tick_s   = &scan_cnt_r;
  assign wrap_s   = tick_s & (idx_r == 2'd3);
  assign bphase_s = blink_cnt_r[BLINK_DIV-1];

  // Staging/shadow next-state: fresh upd data beats older staging at the wrap.
  always_comb begin
    st_hexs_s  = st_hexs_r;
    st_pts_s   = st_pts_r;
    st_le_s    = st_le_r;
    st_blink_s = st_blink_r;
    sh_hexs_s  = sh_hexs_r;
    sh_pts_s   = sh_pts_r;
    sh_le_s    = sh_le_r;
    sh_blink_s = sh_blink_r;
    pending_s  = pending_r;
    if (bus.upd) begin
      st_hexs_s  = bus.hexs;
      st_pts_s   = bus.points;
      st_le_s    = bus.le_mask;
      st_blink_s = bus.blink;
    end else begin
      st_hexs_s  = st_hexs_r;
    end
    if (wrap_s) begin
      pending_s = 1'b0;
      if (bus.upd) begin
        sh_hexs_s  = bus.hexs;
        sh_pts_s   = bus.points;
        sh_le_s    = bus.le_mask;
        sh_blink_s = bus.blink;
      end else if (pending_r) begin
        sh_hexs_s  = st_hexs_r;
        sh_pts_s   = st_pts_r;
        sh_le_s    = st_le_r;
        sh_blink_s = st_blink_r;
      end else begin
        sh_hexs_s  = sh_hexs_r;
      end
    end else if (bus.upd) begin
      pending_s = 1'b1;
    end else begin
      pending_s = pending_r;
    end
  end

  // Free-running scan/blink counters and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_r  <= {SCAN_DIV{1'b0}};
      blink_cnt_r <= {BLINK_DIV{1'b0}};
      idx_r       <= 2'd0;
    end else begin
      scan_cnt_r  <= scan_cnt_r + SCAN_ONE;
      blink_cnt_r <= blink_cnt_r + BLINK_ONE;
      if (tick_s) begin
        idx_r <= idx_r + 2'd1;
      end
    end
  end

  // Staging and shadow register banks; shadow blanking resets dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_hexs_r  <= 16'h0000;
      st_pts_r   <= 4'b0000;
      st_le_r    <= 4'b0000;
      st_blink_r <= 4'b0000;
      sh_hexs_r  <= 16'h0000;
      sh_pts_r   <= 4'b0000;
      sh_le_r    <= 4'b1111;
      sh_blink_r <= 4'b0000;
      pending_r  <= 1'b0;
    end else begin
      st_hexs_r  <= st_hexs_s;
      st_pts_r   <= st_pts_s;
      st_le_r    <= st_le_s;
      st_blink_r <= st_blink_s;
      sh_hexs_r  <= sh_hexs_s;
      sh_pts_r   <= sh_pts_s;
      sh_le_r    <= sh_le_s;
      sh_blink_r <= sh_blink_s;
      pending_r  <= pending_s;
    end
  end

  // Registered slot outputs; anodes go dark for the one cycle after idx advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_r         <= 4'b1111;
      dig_r        <= 4'h0;
      point_r      <= 1'b0;
      le_r         <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      an_r         <= tick_s ? 4'b1111 : ~(4'b0001 << idx_r);
      dig_r        <= sh_hexs_r[{idx_r, 2'b00} +: 4];
      point_r      <= sh_pts_r[idx_r];
      le_r         <= sh_le_r[idx_r] | (sh_blink_r[idx_r] & bphase_s);
      frame_done_r <= wrap_s;
    end
  end

  assign bus.an         = an_r;
  assign bus.dig        = dig_r;
  assign bus.point_out  = point_r;
  assign bus.le_out     = le_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized and directed bench for disp_scan_ctrl against a cycle-count reference model.
module tb_disp_scan_ctrl;
  localparam int S = 2;
  localparam int B = 4;
  localparam int SLOT = 1 << S;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  disp_scan_if bus();
  disp_scan_ctrl #(.SCAN_DIV(S), .BLINK_DIV(B)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;

  // Reference: k = edges since reset release; shadow/staging kept as plain values.
  int          k;
  int          last_fd;
  logic [15:0] m_hex, st_hex;
  logic [3:0]  m_pt, m_le, m_bl, st_pt, st_le, st_bl;
  bit          pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h at k=%0d", tag, obs, exp, k);
    end
  endtask

  task automatic model_reset();
    k = 0; last_fd = -1; pend = 1'b0;
    m_hex = 16'h0000; m_pt = 4'b0000; m_le = 4'b1111; m_bl = 4'b0000;
    st_hex = 16'h0000; st_pt = 4'b0000; st_le = 4'b0000; st_bl = 4'b0000;
  endtask

  task automatic step(input bit u, input logic [15:0] h, input logic [3:0] p,
                      input logic [3:0] l, input logic [3:0] b);
    int idx;
    bit tick, bph, wrap;
    logic [3:0] onehot, e_an, e_dig;
    logic e_pt, e_le;
    bus.upd = u; bus.hexs = h; bus.points = p; bus.le_mask = l; bus.blink = b;
    @(posedge clk);
    idx    = (k / SLOT) % 4;
    tick   = (k % SLOT) == (SLOT - 1);
    bph    = ((k / (1 << (B - 1))) % 2) == 1;
    wrap   = tick && (idx == 3);
    onehot = 4'b0001 << idx;
    e_an   = tick ? 4'b1111 : ~onehot;
    e_dig  = m_hex[idx*4 +: 4];
    e_pt   = m_pt[idx];
    e_le   = m_le[idx] | (m_bl[idx] & bph);
    if (wrap) begin
      if (u) begin m_hex = h; m_pt = p; m_le = l; m_bl = b; end
      else if (pend) begin m_hex = st_hex; m_pt = st_pt; m_le = st_le; m_bl = st_bl; end
      pend = 1'b0;
    end else if (u) begin
      st_hex = h; st_pt = p; st_le = l; st_bl = b; pend = 1'b1;
    end
    k++;
    #1;
    bus.upd = 1'b0;
    check("an", 32'(bus.an), 32'(e_an));
    check("dig", 32'(bus.dig), 32'(e_dig));
    check("point", 32'(bus.point_out), 32'(e_pt));
    check("le", 32'(bus.le_out), 32'(e_le));
    check("frame_done", 32'(bus.frame_done), 32'(wrap));
    if (bus.frame_done === 1'b1) begin
      if (last_fd >= 0) check("fd_period", 32'(k - last_fd), 32'd16);
      last_fd = k;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, bus.hexs, bus.points, bus.le_mask, bus.blink);
  endtask

  initial begin
    bus.upd = 1'b0; bus.hexs = 16'h0000; bus.points = 4'b0000;
    bus.le_mask = 4'b0000; bus.blink = 4'b0000;
    model_reset();
    #12;
    check("rst_an", 32'(bus.an), 32'h0000_000F);
    check("rst_dig", 32'(bus.dig), 32'h0);
    check("rst_point", 32'(bus.point_out), 32'h0);
    check("rst_le", 32'(bus.le_out), 32'h1);
    check("rst_fd", 32'(bus.frame_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame with 1234 and a point on digit 2
    step(1'b1, 16'h1234, 4'b0100, 4'b0000, 4'b0000);
    idle(40);

    // Tearing: two updates inside one frame, last one wins at the wrap
    while (((k / SLOT) % 4) != 1) idle(1);
    step(1'b1, 16'hABCD, 4'b0000, 4'b0000, 4'b0000);
    idle(3);
    step(1'b1, 16'h5678, 4'b0000, 4'b0000, 4'b0000);
    idle(40);

    // Blanked digit 3 and blinking digit 0
    step(1'b1, 16'h5678, 4'b0000, 4'b1000, 4'b0001);
    idle(48);

    // Update landing exactly on the wrap edge
    while ((k % 16) != 15) idle(1);
    step(1'b1, 16'hFFFF, 4'b0000, 4'b0000, 4'b0000);
    idle(36);

    // Random updates
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0)
        step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      else
        idle(1);
    end

    // Reset mid-frame with an update pending
    while (((k / SLOT) % 4) != 2 || (k % SLOT) != 0) idle(1);
    step(1'b1, 16'h9E3C, 4'b1111, 4'b0000, 4'b0000);
    rst_n = 1'b0;
    #1;
    check("mid_rst_an", 32'(bus.an), 32'h0000_000F);
    check("mid_rst_le", 32'(bus.le_out), 32'h1);
    check("mid_rst_dig", 32'(bus.dig), 32'h0);
    model_reset();
    #2;
    rst_n = 1'b1;
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
